// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor on refclk; PLL_SEQ_STATUS_EN adds state_o and lock_loss_cnt.
// Latency: pll_locked reaches the FSM 2 edges later; all outputs registered with state.
// Backpressure: none; restart wins over every state and clears retries.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic refclk,
    input  logic rst,
    input  logic restart,
    input  logic pll_locked,
    output logic pll_rst,
    output logic sys_rst_n,
    output logic ready,
    output logic fail,
    output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1) - 1:0] retry_cnt
`ifdef PLL_SEQ_STATUS_EN
    ,
    output logic [2:0] state_o,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int TMAX = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                          ((PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES) :
                          ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAILED    = 3'd4
    } state_t;

    logic          r_lock_meta;
    logic          r_lock_s;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_retry;
    logic          r_pll_rst;
    logic          r_sys_rst_n;
    logic          r_ready;
    logic          r_fail;

    state_t        w_nxt_state;
    logic [TW-1:0] w_nxt_timer;
    logic [RW-1:0] w_nxt_retry;

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_retry = r_retry;
        if (restart) begin
            w_nxt_state = S_RESET_PLL;
            w_nxt_retry = '0;
        end else begin
            unique case (r_state)
                S_RESET_PLL: begin
                    if (r_timer == TW'(PLL_RST_CYCLES - 1))
                        w_nxt_state = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_nxt_state = S_STABLE;
                    end else if (r_timer == TW'(LOCK_TIMEOUT - 1)) begin
                        if (r_retry == RW'(MAX_RETRIES)) begin
                            w_nxt_state = S_FAILED;
                        end else begin
                            w_nxt_state = S_RESET_PLL;
                            w_nxt_retry = r_retry + 1'b1;
                        end
                    end
                end
                S_STABLE: begin
                    // A lock glitch here is not a timeout: retry count is left alone
                    if (!r_lock_s) begin
                        w_nxt_state = S_WAIT_LOCK;
                    end else if (r_timer == TW'(STABLE_CYCLES - 1)) begin
                        w_nxt_state = S_RUN;
                        w_nxt_retry = '0;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s)
                        w_nxt_state = S_RESET_PLL;
                end
                S_FAILED: begin
                    w_nxt_state = S_FAILED;
                end
                default: begin
                    w_nxt_state = S_RESET_PLL;
                end
            endcase
        end

        // Timer restarts on every state change and saturates rather than wrapping
        if (restart || (w_nxt_state != r_state))
            w_nxt_timer = '0;
        else if (r_timer != TW'(TMAX))
            w_nxt_timer = r_timer + 1'b1;
        else
            w_nxt_timer = r_timer;
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RESET_PLL;
            r_timer     <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_timer     <= w_nxt_timer;
            r_retry     <= w_nxt_retry;
            r_pll_rst   <= (w_nxt_state == S_RESET_PLL) || (w_nxt_state == S_FAILED);
            r_sys_rst_n <= (w_nxt_state == S_RUN);
            r_ready     <= (w_nxt_state == S_RUN);
            r_fail      <= (w_nxt_state == S_FAILED);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst_n = r_sys_rst_n;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retry_cnt = r_retry;

`ifdef PLL_SEQ_STATUS_EN
    logic       w_lock_loss;
    logic [7:0] r_lock_loss_cnt;

    // Only genuine lock loss counts; restart out of RUN does not
    assign w_lock_loss = (r_state == S_RUN) && !r_lock_s && !restart;

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst)
            r_lock_loss_cnt <= 8'd0;
        else if (w_lock_loss && (r_lock_loss_cnt != 8'hFF))
            r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end

    assign state_o       = r_state;
    assign lock_loss_cnt = r_lock_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed edge-accurate scenarios plus randomized lock behaviour
// compared every cycle against a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

    localparam int RC  = 4;
    localparam int TO  = 100;
    localparam int SC  = 8;
    localparam int MR  = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       restart    = 1'b0;
    logic       pll_locked = 1'b1;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
`ifdef PLL_SEQ_STATUS_EN
    logic [2:0] state_o;
    logic [7:0] lock_loss_cnt;
`endif

    int n_chk  = 0;
    int n_bad  = 0;
    int edge_n = 0;

    int m_ph;
    int m_since;
    int m_retry;
    int m_losses;
    bit m_sync0;
    bit m_sync1;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (RC),
        .LOCK_TIMEOUT   (TO),
        .STABLE_CYCLES  (SC),
        .MAX_RETRIES    (MR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .restart    (restart),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
`ifdef PLL_SEQ_STATUS_EN
        ,
        .state_o       (state_o),
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph     = P_RST;
        m_since  = 0;
        m_retry  = 0;
        m_losses = 0;
        m_sync0  = 1'b0;
        m_sync1  = 1'b0;
    endtask

    task automatic model_enter(input int ph);
        m_ph    = ph;
        m_since = 0;
    endtask

    // One refclk edge: the phase sees lock as it was two samples ago
    task automatic model_step();
        bit ls;
        ls      = m_sync1;
        m_sync1 = m_sync0;
        m_sync0 = pll_locked;
        if (restart) begin
            model_enter(P_RST);
            m_retry = 0;
        end else begin
            m_since++;
            case (m_ph)
                P_RST:  if (m_since >= RC) model_enter(P_WAIT);
                P_WAIT: begin
                    if (ls) model_enter(P_STB);
                    else if (m_since >= TO) begin
                        if (m_retry >= MR) model_enter(P_FAIL);
                        else begin
                            m_retry++;
                            model_enter(P_RST);
                        end
                    end
                end
                P_STB: begin
                    if (!ls) model_enter(P_WAIT);
                    else if (m_since >= SC) begin
                        model_enter(P_RUN);
                        m_retry = 0;
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        model_enter(P_RST);
                        if (m_losses < 255) m_losses++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk_eq("mdl_pll_rst",   pll_rst,   (m_ph == P_RST) || (m_ph == P_FAIL));
        chk_eq("mdl_sys_rst_n", sys_rst_n, m_ph == P_RUN);
        chk_eq("mdl_ready",     ready,     m_ph == P_RUN);
        chk_eq("mdl_fail",      fail,      m_ph == P_FAIL);
        chk_eq("mdl_retry_cnt", retry_cnt, m_retry);
`ifdef PLL_SEQ_STATUS_EN
        chk_eq("mdl_state_o",       state_o,       m_ph);
        chk_eq("mdl_lock_loss_cnt", lock_loss_cnt, m_losses);
`endif
    endtask

    task automatic cyc();
        @(posedge refclk);
        model_step();
        #1;
        edge_n++;
        check_outputs();
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) cyc();
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        edge_n  = 0;
    endtask

    initial begin
        int seg;
        int mode;

        // Power-on reset
        #1 rst = 1'b0;
        model_reset();
        #2;
        chk_eq("por_pll_rst",   pll_rst,   1);
        chk_eq("por_sys_rst_n", sys_rst_n, 0);
        chk_eq("por_ready",     ready,     0);
        chk_eq("por_fail",      fail,      0);
        chk_eq("por_retry_cnt", retry_cnt, 0);
        #9 rst = 1'b1;
        edge_n = 0;

        // Clean start with lock held high
        run_to(3);
        chk_eq("clean_pll_rst_e3", pll_rst, 1);
        cyc();
        chk_eq("clean_pll_rst_e4", pll_rst, 0);
        run_to(12);
        chk_eq("clean_sys_rst_n_e12", sys_rst_n, 0);
        cyc();
        chk_eq("clean_sys_rst_n_e13", sys_rst_n, 1);
        chk_eq("clean_ready_e13",     ready,     1);
        chk_eq("clean_retry_e13",     retry_cnt, 0);
        run_to(20);

        // One-cycle lock drop while in RUN
        pll_locked = 1'b0;
        cyc();
        pll_locked = 1'b1;
        cyc();
        chk_eq("loss_sys_rst_n_held", sys_rst_n, 1);
        cyc();
        chk_eq("loss_sys_rst_n_drop", sys_rst_n, 0);
        chk_eq("loss_pll_rst",        pll_rst,   1);
        run_to(35);
        chk_eq("loss_ready_e35", ready, 0);
        cyc();
        chk_eq("loss_ready_e36", ready, 1);
`ifdef PLL_SEQ_STATUS_EN
        chk_eq("loss_count", lock_loss_cnt, 1);
`endif

        // Lock glitch while STABLE has counted to 5
        pulse_restart();
        chk_eq("glitch_restart_sys_rst_n", sys_rst_n, 0);
        run_to(8);
        pll_locked = 1'b0;
        cyc();
        pll_locked = 1'b1;
        run_to(19);
        chk_eq("glitch_ready_e19", ready, 0);
        cyc();
        chk_eq("glitch_ready_e20", ready,     1);
        chk_eq("glitch_retry",     retry_cnt, 0);

        // Lock never arrives: three timeouts then FAILED
        pll_locked = 1'b0;
        pulse_restart();
        run_to(103);
        chk_eq("to_pll_rst_e103", pll_rst,   0);
        chk_eq("to_retry_e103",   retry_cnt, 0);
        cyc();
        chk_eq("to_pll_rst_e104", pll_rst,   1);
        chk_eq("to_retry_e104",   retry_cnt, 1);
        run_to(207);
        chk_eq("to_retry_e207", retry_cnt, 1);
        cyc();
        chk_eq("to_retry_e208", retry_cnt, 2);
        run_to(311);
        chk_eq("to_fail_e311", fail, 0);
        cyc();
        chk_eq("to_fail_e312",    fail,      1);
        chk_eq("to_pll_rst_e312", pll_rst,   1);
        chk_eq("to_retry_e312",   retry_cnt, 2);
        run_to(330);
        chk_eq("to_fail_hold",    fail,    1);
        chk_eq("to_pll_rst_hold", pll_rst, 1);

        // Restart out of FAILED with lock present
        pll_locked = 1'b1;
        run_to(335);
        chk_eq("rf_fail_before", fail, 1);
        pulse_restart();
        chk_eq("rf_retry",   retry_cnt, 0);
        chk_eq("rf_fail",    fail,      0);
        chk_eq("rf_pll_rst", pll_rst,   1);
        run_to(12);
        chk_eq("rf_sys_rst_n_e12", sys_rst_n, 0);
        cyc();
        chk_eq("rf_sys_rst_n_e13", sys_rst_n, 1);

        // Asynchronous reset in the middle of WAIT_LOCK after one timeout
        pll_locked = 1'b0;
        pulse_restart();
        run_to(110);
        chk_eq("ar_pre_retry",   retry_cnt, 1);
        chk_eq("ar_pre_pll_rst", pll_rst,   0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk_eq("ar_pll_rst",   pll_rst,   1);
        chk_eq("ar_sys_rst_n", sys_rst_n, 0);
        chk_eq("ar_ready",     ready,     0);
        chk_eq("ar_fail",      fail,      0);
        chk_eq("ar_retry_cnt", retry_cnt, 0);
        #2 rst = 1'b1;
        edge_n = 0;

        // Randomized lock behaviour with occasional restarts
        seg  = 0;
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                mode = $urandom_range(0, 2);
                case (mode)
                    0:       seg = $urandom_range(20, 200);
                    1:       seg = $urandom_range(1, 400);
                    default: seg = $urandom_range(1, 10);
                endcase
            end
            seg--;
            case (mode)
                0:       pll_locked = 1'b1;
                1:       pll_locked = 1'b0;
                default: pll_locked = $urandom_range(0, 1) == 1;
            endcase
            restart = ($urandom_range(0, 299) == 0);
            cyc();
        end
        restart = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
